// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader.
//   SYNC_BYTE / CHK_SEED : packet framing constants
//   rx_state_t           : UART receiver states
//   pkt_state_t          : packet parser states
//   calc_chk()           : expected CHK byte for an ADDR/VALUE pair
package loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_SEED  = 8'h5A;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_SYNC, P_ADDR, P_VAL, P_CHK}    pkt_state_t;

  function automatic logic [7:0] calc_chk(input logic [7:0] addr, input logic [7:0] val);
    return addr ^ val ^ CHK_SEED;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser plus bit-timing FSM.
//   clk, rst_n : clock, async active-low reset
//   uart_rxd   : raw serial input (idle high)
//   rx_byte    : last received data byte (valid while byte_valid is high)
//   byte_valid : one-cycle pulse on the stop-bit sample when the stop bit is 1
//   frame_err  : one-cycle pulse on the stop-bit sample when the stop bit is 0
// byte_valid/frame_err are decoded from the state registers so that the
// consumer can register its reaction on the very same edge as the sample.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int BIT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int             CW        = $clog2(BIT_CYC);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CYC / 2 - 1);

  logic            rxd_m, rxd_s, rxd_q;
  rx_state_t       state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, sh_n;

  // Synchroniser and edge-detect history reset high so that a line held
  // idle through reset is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m   <= 1'b1;
      rxd_s   <= 1'b1;
      rxd_q   <= 1'b1;
      state   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      rxd_m   <= uart_rxd;
      rxd_s   <= rxd_m;
      rxd_q   <= rxd_s;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    sh_n       = shreg;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      R_IDLE: begin
        if (rxd_q && !rxd_s) begin
          state_n = R_START;
          cnt_n   = '0;
          bit_n   = '0;
        end
      end
      // Half a bit later we are mid start bit; a high line means it was a glitch.
      R_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          state_n = rxd_s ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          sh_n  = {rxd_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = R_STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          state_n = R_IDLE;
          if (rxd_s) byte_valid = 1'b1;
          else       frame_err  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/serial_prog_loader.sv
// Serial program loader: parses SYNC/ADDR/VALUE/CHK packets from a UART
// and drives the program memory's serial write port.
//   clk, rst_n     : clock, async active-low reset
//   uart_rxd       : serial input (idle high)
//   addr, value    : address/data of the last committed packet
//   serial_WE      : one-cycle write strobe, coincident with addr/value update
//   busy           : packet parser is inside a packet
//   frame_err      : pulse, stop bit sampled low
//   chk_err        : pulse, bad checksum or ADDR[7:4] != 0
//   timeout        : pulse, inter-byte gap inside a packet too long
//   last_addr_led  : mirror of addr for the status LEDs
module serial_prog_loader
  import loader_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 16 * (CLK_HZ / BAUD) * 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [3:0] addr,
  output logic [7:0] value,
  output logic       serial_WE,
  output logic       busy,
  output logic       frame_err,
  output logic       chk_err,
  output logic       timeout,
  output logic [3:0] last_addr_led
);

  localparam int            BIT_CYC = CLK_HZ / BAUD;
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  if (BIT_CYC < 4) begin : g_bit_cyc_check
    $error("serial_prog_loader: CLK_HZ/BAUD must be at least 4");
  end

  logic [7:0]  rx_byte;
  logic        byte_valid, rx_frame_err;

  uart_rx_core #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rxd   (uart_rxd),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_frame_err)
  );

  pkt_state_t  state, state_n;
  logic [7:0]  sh_addr, sh_val;
  logic [TW-1:0] tcnt;
  logic        we_n, fe_n, ce_n, to_n;

  // Error sources are mutually exclusive by construction: the receiver never
  // flags a byte and a framing error together, a checksum verdict needs a
  // byte, and the timeout branch is only reached when neither happened.
  always_comb begin
    state_n = state;
    we_n    = 1'b0;
    fe_n    = 1'b0;
    ce_n    = 1'b0;
    to_n    = 1'b0;
    if (rx_frame_err) begin
      fe_n    = 1'b1;
      state_n = P_SYNC;
    end else if (byte_valid) begin
      case (state)
        P_SYNC: if (rx_byte == SYNC_BYTE) state_n = P_ADDR;
        P_ADDR: state_n = P_VAL;
        P_VAL:  state_n = P_CHK;
        P_CHK: begin
          state_n = P_SYNC;
          if (rx_byte == calc_chk(sh_addr, sh_val) && sh_addr[7:4] == 4'h0) we_n = 1'b1;
          else                                                              ce_n = 1'b1;
        end
        default: state_n = P_SYNC;
      endcase
    end else if (state != P_SYNC && tcnt == TO_LAST) begin
      to_n    = 1'b1;
      state_n = P_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= P_SYNC;
      sh_addr   <= '0;
      sh_val    <= '0;
      tcnt      <= '0;
      addr      <= '0;
      value     <= '0;
      serial_WE <= 1'b0;
      frame_err <= 1'b0;
      chk_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      serial_WE <= we_n;
      frame_err <= fe_n;
      chk_err   <= ce_n;
      timeout   <= to_n;
      if (byte_valid && state == P_ADDR) sh_addr <= rx_byte;
      if (byte_valid && state == P_VAL)  sh_val  <= rx_byte;
      // Gap timer restarts on every byte and is held at zero outside a packet.
      if (byte_valid || state_n == P_SYNC) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;
      if (we_n) begin
        addr  <= sh_addr[3:0];
        value <= sh_val;
      end
    end
  end

  assign busy          = (state != P_SYNC);
  assign last_addr_led = addr;

endmodule

// File: tb/tb_serial_prog_loader.sv
module tb_serial_prog_loader;

  localparam int BIT = 16;   // 160 Hz / 10 baud

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [3:0] addr, last_addr_led;
  logic [7:0] value;
  logic       serial_WE, busy, frame_err, chk_err, timeout;

  serial_prog_loader #(.CLK_HZ(160), .BAUD(10), .TIMEOUT_CYC(400)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rxd      (uart_rxd),
    .addr          (addr),
    .value         (value),
    .serial_WE     (serial_WE),
    .busy          (busy),
    .frame_err     (frame_err),
    .chk_err       (chk_err),
    .timeout       (timeout),
    .last_addr_led (last_addr_led)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int we_cnt = 0, fe_cnt = 0, ce_cnt = 0, to_cnt = 0, overlap = 0;
  int last_we_cyc = 0, last_to_cyc = 0, t_start = 0;
  logic we_prev = 1'b0;
  logic [11:0] we_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: logs strobes and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (serial_WE) begin
        we_cnt++;
        we_q.push_back({addr, value});
        last_we_cyc = cyc;
      end
      if (frame_err) fe_cnt++;
      if (chk_err)   ce_cnt++;
      if (timeout) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
      if (serial_WE && (frame_err || chk_err || timeout)) overlap++;
      if (int'(frame_err) + int'(chk_err) + int'(timeout) > 1) overlap++;
      if (serial_WE && we_prev) overlap++;
      we_prev = serial_WE;
    end
  end

  // Called at a negedge; returns at the negedge that starts the next bit slot.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    t_start  = cyc;
    uart_rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT) @(negedge clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] v, input logic [7:0] c);
    send_byte(8'hA5, 1'b1);
    send_byte(a, 1'b1);
    send_byte(v, 1'b1);
    send_byte(c, 1'b1);
  endtask

  task automatic test_reset;
    repeat (4) @(posedge clk);
    n_tests++;
    if ({addr, value, serial_WE, busy, frame_err, chk_err, timeout, last_addr_led} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {addr, value, serial_WE, busy, frame_err, chk_err, timeout, last_addr_led});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if ({addr, value, busy, last_addr_led} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want 0", {addr, value, busy, last_addr_led});
    end
  endtask

  task automatic test_reset_mid;
    int w0, e0;
    @(posedge clk); w0 = we_cnt; e0 = fe_cnt + ce_cnt + to_cnt; @(negedge clk);
    send_byte(8'hA5, 1'b1);
    uart_rxd = 1'b0; repeat (BIT) @(negedge clk);     // start of ADDR byte
    uart_rxd = 1'b1; repeat (BIT + 8) @(negedge clk); // into the data bits
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    n_tests++;
    if ({busy, addr, value} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %h want 0", {busy, addr, value});
    end
    send_pkt(8'h03, 8'hC4, 8'h9D);
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_cnt - w0 != 1 || addr !== 4'h3 || value !== 8'hC4) begin
      n_fail++;
      $display("FAIL reset_mid_commit: got we=%0d addr=%h val=%h want we=1 addr=3 val=c4", we_cnt - w0, addr, value);
    end
    n_tests++;
    if (fe_cnt + ce_cnt + to_cnt != e0) begin
      n_fail++;
      $display("FAIL reset_mid_errs: got %0d want %0d", fe_cnt + ce_cnt + to_cnt, e0);
    end
    @(negedge clk);
  endtask

  task automatic test_commit;
    int w0;
    @(posedge clk); w0 = we_cnt; @(negedge clk);
    send_pkt(8'h07, 8'h11, 8'h4C);
    repeat (4) @(posedge clk);
    // Start edge seen by the 2-FF sync after 2 clocks, FSM leaves idle one
    // clock later, half bit + 8 data bits + stop bit, strobe on the next clock.
    n_tests++;
    if (we_cnt - w0 != 1 || last_we_cyc != t_start + 155) begin
      n_fail++;
      $display("FAIL commit_latency: got we=%0d cyc=%0d want we=1 cyc=%0d", we_cnt - w0, last_we_cyc, t_start + 155);
    end
    n_tests++;
    if (addr !== 4'h7 || value !== 8'h11 || last_addr_led !== 4'h7) begin
      n_fail++;
      $display("FAIL commit_data: got addr=%h val=%h led=%h want 7 11 7", addr, value, last_addr_led);
    end
    @(negedge clk);
  endtask

  task automatic test_chk_err;
    int w0, c0;
    @(posedge clk); w0 = we_cnt; c0 = ce_cnt; @(negedge clk);
    send_pkt(8'h07, 8'h11, 8'h4D);
    repeat (4) @(posedge clk);
    n_tests++;
    if (ce_cnt - c0 != 1 || we_cnt != w0 || addr !== 4'h7 || value !== 8'h11) begin
      n_fail++;
      $display("FAIL chk_bad_sum: got ce=%0d we=%0d addr=%h val=%h want 1 0 7 11", ce_cnt - c0, we_cnt - w0, addr, value);
    end
    @(negedge clk);
    send_pkt(8'h17, 8'h11, 8'h5C);
    repeat (4) @(posedge clk);
    n_tests++;
    if (ce_cnt - c0 != 2 || we_cnt != w0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL chk_hi_nibble: got ce=%0d we=%0d busy=%b want 2 0 0", ce_cnt - c0, we_cnt - w0, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_garbage;
    int w0;
    @(posedge clk); w0 = we_cnt; @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_pkt(8'h02, 8'h80, 8'hD8);
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_cnt - w0 != 1 || addr !== 4'h2 || value !== 8'h80) begin
      n_fail++;
      $display("FAIL garbage: got we=%0d addr=%h val=%h want 1 2 80", we_cnt - w0, addr, value);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int w0, to0, t5;
    @(posedge clk); w0 = we_cnt; to0 = to_cnt; @(negedge clk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h05, 1'b1);
    t5 = t_start;
    repeat (200) @(posedge clk);
    n_tests++;
    if (busy !== 1'b1 || to_cnt != to0) begin
      n_fail++;
      $display("FAIL timeout_early: got busy=%b to=%0d want 1 0", busy, to_cnt - to0);
    end
    for (int i = 0; i < 400 && to_cnt == to0; i++) @(posedge clk);
    n_tests++;
    if (to_cnt - to0 != 1 || last_to_cyc != t5 + 555) begin
      n_fail++;
      $display("FAIL timeout_fire: got n=%0d cyc=%0d want 1 %0d", to_cnt - to0, last_to_cyc, t5 + 555);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || we_cnt != w0) begin
      n_fail++;
      $display("FAIL timeout_abort: got busy=%b we=%0d want 0 0", busy, we_cnt - w0);
    end
    send_pkt(8'h05, 8'hAA, 8'hF5);
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_cnt - w0 != 1 || addr !== 4'h5 || value !== 8'hAA) begin
      n_fail++;
      $display("FAIL timeout_recover: got we=%0d addr=%h val=%h want 1 5 aa", we_cnt - w0, addr, value);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_glitch;
    int w0, f0, c0;
    @(posedge clk); w0 = we_cnt; f0 = fe_cnt; c0 = ce_cnt; @(negedge clk);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'hC4, 1'b0);
    repeat (BIT) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL frame_abort: got busy=%b fe=%0d want 0 1", busy, fe_cnt - f0);
    end
    send_byte(8'h9D, 1'b1);   // would have completed the packet
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_cnt != w0 || ce_cnt != c0 || addr !== 4'h5) begin
      n_fail++;
      $display("FAIL frame_no_commit: got we=%0d ce=%0d addr=%h want 0 0 5", we_cnt - w0, ce_cnt - c0, addr);
    end
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (200) @(negedge clk);
    @(posedge clk);
    n_tests++;
    if (fe_cnt - f0 != 1 || busy !== 1'b0 || we_cnt != w0) begin
      n_fail++;
      $display("FAIL glitch: got fe=%0d busy=%b we=%0d want 1 0 0", fe_cnt - f0, busy, we_cnt - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int base, e0;
    logic [7:0] v;
    logic [11:0] exp_q[$];
    @(posedge clk); base = we_q.size(); e0 = fe_cnt + ce_cnt + to_cnt; @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      v = 8'($urandom_range(0, 255));
      exp_q.push_back({4'(a), v});
      send_pkt(8'(a), v, 8'(a) ^ v ^ 8'h5A);
    end
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_q.size() - base != 16 || fe_cnt + ce_cnt + to_cnt != e0) begin
      n_fail++;
      $display("FAIL b2b_count: got we=%0d errs=%0d want 16 0", we_q.size() - base, fe_cnt + ce_cnt + to_cnt - e0);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_tests++;
        if (we_q[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got %h want %h", i, we_q[base + i], exp_q[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  // Reference: a packet commits iff CHK equals ADDR^VALUE^5A and ADDR < 16.
  task automatic test_random;
    int base, c0, exp_ce;
    logic [7:0] a, v, c;
    logic [11:0] exp_q[$];
    exp_ce = 0;
    @(posedge clk); base = we_q.size(); c0 = ce_cnt; @(negedge clk);
    for (int n = 0; n < 10; n++) begin
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a[7:4] = 4'($urandom_range(1, 15));
      v = 8'($urandom_range(0, 255));
      c = a ^ v ^ 8'h5A;
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      if (c == (a ^ v ^ 8'h5A) && a[7:4] == 4'h0) exp_q.push_back({a[3:0], v});
      else exp_ce++;
      send_pkt(a, v, c);
    end
    repeat (4) @(posedge clk);
    n_tests++;
    if (we_q.size() - base != exp_q.size() || ce_cnt - c0 != exp_ce) begin
      n_fail++;
      $display("FAIL rand_count: got we=%0d ce=%0d want %0d %0d", we_q.size() - base, ce_cnt - c0, exp_q.size(), exp_ce);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (we_q[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: got %h want %h", i, we_q[base + i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL pulse_rules: got %0d violations want 0", overlap);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_commit;
    test_chk_err;
    test_garbage;
    test_timeout;
    test_frame_glitch;
    test_back_to_back;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_prog_loader.md
Name: serial_prog_loader

Overview:
- Upstream feeder of the program memory's serial write port.
- Receives 8N1 UART bytes on `uart_rxd` and parses 4-byte load packets: `SYNC 0xA5`, `ADDR`, `VALUE`, `CHK`.
- For each valid packet, presents a 4-bit address and 8-bit value and pulses a one-cycle write strobe. The memory consumes `addr`, `value` and `serial_WE` directly.
- Also reports framing, checksum and timeout errors, and the last address written.

Parameters:
- `CLK_HZ`, 50000000, input clock frequency in Hz.
- `BAUD`, 115200, serial bit rate. `BIT_CYC = CLK_HZ/BAUD` (integer division) must be ≥ 4; elaboration fails otherwise.
- `TIMEOUT_CYC`, `16*BIT_CYC*10`, maximum idle cycles allowed between bytes inside a packet.

Ports:
- `clk`  in  1  system clock (`CLOCK_50` domain).
- `rst_n`  in  1  asynchronous, active-low reset.
- `uart_rxd`  in  1  asynchronous serial input; idle high.
- `addr`  out  4  memory address of the last accepted packet.
- `value`  out  8  data of the last accepted packet.
- `serial_WE`  out  1  one-cycle write strobe.
- `busy`  out  1  high while the packet FSM is outside `P_SYNC`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `chk_err`  out  1  one-cycle pulse: bad checksum or nonzero `ADDR[7:4]`.
- `timeout`  out  1  one-cycle pulse: inter-byte timeout fired.
- `last_addr_led`  out  4  equals `addr`; drives status LEDs.

Behaviour:
- Reset state: all outputs 0, both FSMs idle, synchroniser flops set to 1. Reset applies immediately from any state; a partial packet is discarded and no strobe is issued.
- Input path: 2-FF synchroniser on `uart_rxd`; the RX FSM sees the synchronised `rxd_s` only.
- RX FSM states:
  - `R_IDLE`: a falling edge of `rxd_s` → `R_START`, bit counter cleared.
  - `R_START`: wait `BIT_CYC/2` cycles. If `rxd_s` is still 0 → `R_DATA`; if 1 (glitch) → `R_IDLE`, no error.
  - `R_DATA`: sample every `BIT_CYC` cycles, LSB first, 8 bits → `R_STOP`.
  - `R_STOP`: after `BIT_CYC` cycles, sample. If 1, pulse internal `byte_valid` one cycle with `rx_byte`. If 0, pulse `frame_err` and drop the byte. Either way → `R_IDLE`.
- Packet FSM; every transition happens only on `byte_valid`, except timeout, reset and frame error:
  - `P_SYNC`: byte `0xA5` → `P_ADDR`; any other byte is ignored silently.
  - `P_ADDR`: latch the byte in a shadow register → `P_VAL`.
  - `P_VAL`: latch the byte in a shadow register → `P_CHK`.
  - `P_CHK`: the expected checksum is `ADDR ^ VALUE ^ 0x5A`.
    - Match and `ADDR[7:4]==0` → commit and return to `P_SYNC`.
    - Otherwise pulse `chk_err` → `P_SYNC`.
- Commit: on the cycle after `byte_valid` for `CHK`, `addr`/`value` update from the shadows and `serial_WE`=1 for exactly that cycle. `addr`/`value` then hold until the next commit.
- Latency: `serial_WE` rises 1 cycle after the stop-bit sample of the `CHK` byte.
- Timeout counter:
  - Cleared on every `byte_valid`; counts while `busy`.
  - Reaching `TIMEOUT_CYC` pulses `timeout` → `P_SYNC`.
  - If timeout and `byte_valid` occur in the same cycle, `byte_valid` wins.
- Frame error while `busy` → `P_SYNC` (packet aborted); `frame_err` pulses as usual.
- Simultaneous events: at most one error pulse per cycle. Priority: `frame_err` > `chk_err` > `timeout`.
- `serial_WE` never asserts in the same cycle as any error pulse.
- Back-to-back packets with no idle bits between them must be accepted without loss.

Decomposition:
- `loader_pkg`:
  - constants `SYNC_BYTE`=8'hA5 and `CHK_SEED`=8'h5A;
  - enums `rx_state_t` {`R_IDLE`,`R_START`,`R_DATA`,`R_STOP`} and `pkt_state_t` {`P_SYNC`,`P_ADDR`,`P_VAL`,`P_CHK`};
  - function `calc_chk(addr,val)`.
- Sub-module `uart_rx_core`:
  - contents: synchroniser plus RX FSM, parameterised by `BIT_CYC`;
  - outputs: `rx_byte`[7:0], `byte_valid`, `frame_err`.
- The top level holds the packet FSM, timeout counter and output registers.

Test Plan (all scenarios use `CLK_HZ`=160, `BAUD`=10, so `BIT_CYC`=16, `TIMEOUT_CYC`=400):
- Reset mid-`DATA` bits of an `ADDR` byte (`rst_n` low 3 cycles), then a clean packet `A5,03,C4,9D` → exactly one `serial_WE` with `addr`=3, `value`=0xC4; no error pulses.
- Packet `A5,07,11,4C` (checksum 07^11^5A=4C) → `serial_WE` 1 cycle after the `CHK` stop sample; `addr`=7, `value`=0x11, `last_addr_led`=7.
- Packet `A5,07,11,4D` → `chk_err` one pulse, no `serial_WE`, `addr`/`value` unchanged. Packet `A5,17,11,5C` → `chk_err` (upper nibble set).
- Garbage `00,FF,A5,02,80,D8` → bytes before `A5` ignored; commit `addr`=2, `value`=0x80.
- `A5,05` then silence for 400 cycles → `timeout` pulse, `busy`=0. A following `A5,05,AA,F5` commits `addr`=5, `value`=0xAA.
- Stop bit forced low on the `VAL` byte → `frame_err` pulse, packet aborted. A 4-cycle low glitch on idle line → no byte, no error. 16 back-to-back packets to addresses 0..15 → 16 strobes, in order.
